// File: rtl/cmd_run_pkg.sv
// Shared types and defaults for the command run sequencer.
package cmd_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        EXEC,
        RESP
    } state_e;

    typedef enum logic {
        SEL_COMMAND = 1'b0,
        SEL_FLAG    = 1'b1
    } exec_sel_e;

    localparam int DEFAULT_TIMEOUT_EXIT = 124;

endpackage

// File: rtl/first_flag_select.sv
// Lowest-set-bit priority encoder: picks the terminating flag whose handler runs.
module first_flag_select #(
    parameter  int NUM_FLAGS = 8,
    localparam int IDX_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
) (
    input  logic [NUM_FLAGS-1:0] hits,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        found = 1'b0;
        idx   = '0;
        // Scan from the top down so the lowest set bit is the last to write idx.
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/command_run_sequencer.sv
// Sequences one command request at a time onto the shared executor port,
// choosing between the command body and the first terminating flag handler.
module command_run_sequencer
    import cmd_run_pkg::*;
#(
    parameter  int NUM_FLAGS      = 8,
    parameter  int EXIT_W         = 8,
    parameter  int OUT_W          = 16,
    parameter  int TIMEOUT_CYCLES = 1024,
    parameter  int TIMEOUT_EXIT   = DEFAULT_TIMEOUT_EXIT,
    localparam int IDX_W          = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1,
    localparam int CNT_W          = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [NUM_FLAGS-1:0] cmd_flags,
    input  logic [NUM_FLAGS-1:0] cmd_term_mask,
    output logic                 exec_req,
    output logic                 exec_sel,
    output logic [IDX_W-1:0]     exec_flag_idx,
    input  logic                 exec_done,
    input  logic [EXIT_W-1:0]    exec_exit_code,
    input  logic [OUT_W-1:0]     exec_output,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [EXIT_W-1:0]    res_exit_code,
    output logic [OUT_W-1:0]     res_output,
    output logic                 res_timeout,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [NUM_FLAGS-1:0] hits_q, hits_d;
    exec_sel_e            sel_q, sel_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [EXIT_W-1:0]    exit_q, exit_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 to_q, to_d;
    logic                 ready_q;

    logic                 enc_found;
    logic [IDX_W-1:0]     enc_idx;
    logic                 expired;

    first_flag_select #(
        .NUM_FLAGS(NUM_FLAGS)
    ) u_first_flag_select (
        .hits (hits_q),
        .found(enc_found),
        .idx  (enc_idx)
    );

    // A zero timeout never expires, leaving the executor unbounded.
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        hits_d  = hits_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exit_d  = exit_q;
        out_d   = out_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    hits_d  = cmd_flags & cmd_term_mask;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                sel_d   = enc_found ? SEL_FLAG : SEL_COMMAND;
                idx_d   = enc_found ? enc_idx : '0;
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                // A completion in the expiry cycle still reports the executor's result.
                if (exec_done) begin
                    exit_d  = exec_exit_code;
                    out_d   = exec_output;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (expired) begin
                    exit_d  = EXIT_W'(TIMEOUT_EXIT);
                    out_d   = '0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hits_q  <= '0;
            sel_q   <= SEL_COMMAND;
            idx_q   <= '0;
            cnt_q   <= '0;
            exit_q  <= '0;
            out_q   <= '0;
            to_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            hits_q  <= hits_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exit_q  <= exit_d;
            out_q   <= out_d;
            to_q    <= to_d;
            ready_q <= (state_d == IDLE);
        end
    end

    // cmd_ready is registered so it stays low throughout reset and rises one cycle after release.
    assign cmd_ready     = ready_q;
    assign exec_req      = (state_q == EXEC);
    assign exec_sel      = sel_q;
    assign exec_flag_idx = idx_q;
    assign res_valid     = (state_q == RESP);
    assign res_exit_code = exit_q;
    assign res_output    = out_q;
    assign res_timeout   = to_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/command_run_sequencer.md
Name: command_run_sequencer

Overview:
- Hardware dispatcher for a command request. Each request carries a set-flag vector and a terminating-flag mask.
- If any set flag is terminating, the lowest-indexed such flag's handler executes instead of the command body. Otherwise the command executor runs.
- Sits between the request front-end and the shared executor port. Sequences one request at a time and returns exit code plus output descriptor to the requester.

Parameters:
- NUM_FLAGS, 8: number of flag slots.
- EXIT_W, 8: exit code width.
- OUT_W, 16: output descriptor width (length/pointer, opaque to this block).
- TIMEOUT_CYCLES, 1024: max cycles exec_req may wait for exec_done; 0 disables the timeout.
- TIMEOUT_EXIT, 124: exit code reported on timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accept
- cmd_flags  in  NUM_FLAGS  flags present on the command
- cmd_term_mask  in  NUM_FLAGS  flags that are terminating
- exec_req  out  1  executor start/hold
- exec_sel  out  1  0 = command body, 1 = flag handler
- exec_flag_idx  out  $clog2(NUM_FLAGS)  selected flag index; 0 when exec_sel=0
- exec_done  in  1  executor completion pulse
- exec_exit_code  in  EXIT_W  executor exit code, valid with exec_done
- exec_output  in  OUT_W  executor output descriptor, valid with exec_done
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_exit_code  out  EXIT_W  result exit code
- res_output  out  OUT_W  result output descriptor
- res_timeout  out  1  result produced by timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, synchronous deassert (externally synchronised).
- Reset values: all outputs 0, with one exception: cmd_ready=1 one cycle after deassertion (IDLE). State goes to IDLE.
- FSM states: IDLE, SELECT, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register flags & term_mask as hits, then go to SELECT.
- SELECT (1 cycle):
  - Priority-encode hits; lowest set bit wins.
  - Any hit: exec_sel=1, exec_flag_idx=index.
  - No hit: exec_sel=0, idx=0.
  - Clear the timeout counter, then go to EXEC.
- EXEC:
  - exec_req=1; exec_sel and exec_flag_idx are held stable.
  - exec_done sampled only in EXEC and ignored in all other states.
  - On exec_done: capture exit code and output, res_timeout=0, go to RESP; exec_req drops the next cycle.
  - Timeout counter increments each EXEC cycle without done. At count==TIMEOUT_CYCLES: res_exit_code=TIMEOUT_EXIT, res_output=0, res_timeout=1, go to RESP.
  - exec_done in the same cycle as expiry: done wins.
- RESP:
  - res_valid=1; data held stable until res_ready.
  - On res_valid&&res_ready go to IDLE; the next request can be accepted the following cycle.
  - res_valid never drops without a handshake.
- Latency, accept in cycle 0:
  - exec_req first high in cycle 2.
  - exec_done in cycle N gives res_valid in cycle N+1.
  - Minimum accept-to-result is 3 cycles, when done arrives in cycle 2.
- Boundary cases:
  - A flag in cmd_term_mask but not in cmd_flags is not a hit.
  - All-ones hits select index 0.
  - Only the MSB set selects NUM_FLAGS-1.
  - cmd_valid while busy: cmd_ready=0, so the request is not consumed.
- Reset mid-operation: the in-flight request is dropped and no result is produced. exec_req deasserts asynchronously.

Decomposition:
- Package cmd_run_pkg holds:
  - state enum {IDLE, SELECT, EXEC, RESP}
  - exec_sel enum {SEL_COMMAND=0, SEL_FLAG=1}
  - default TIMEOUT_EXIT constant
- Sub-module first_flag_select: combinational lowest-set-bit priority encoder.
  - Parameter NUM_FLAGS.
  - Outputs found and idx.
- FSM, timeout counter and result registers stay in command_run_sequencer.

Test Plan:
- No terminating hits: flags=0x05, mask=0x00 → exec_sel=0, idx=0; done in cycle 2 with exit=0, output=0x0040 → res_valid in cycle 3, exit=0, output=0x0040, timeout=0.
- Terminating hit: flags=0x2C, mask=0x28 → exec_sel=1, idx=3; done exit=1 → res_exit_code=1.
- Timeout: TIMEOUT_CYCLES=4, no done → res_exit_code=124, res_timeout=1, res_output=0; a late exec_done in RESP is ignored.
- Backpressure: res_ready low for 5 cycles → result stable; cmd_ready=0 throughout; new cmd_valid accepted only the cycle after the res handshake.
- Reset in EXEC: rst_n low with exec_req high → all outputs 0 immediately; after release, cmd_ready=1 and a new request completes normally.
